// File: rtl/ixc_sample_hist.sv
// rtl/ixc_sample_hist.sv - probe sampler with circular trigger history streamed oldest-first
module ixc_sample_hist #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int POST  = 4
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] ov,
    output logic             chg,
    input  logic             smp_en,
    input  logic             arm,
    input  logic             trig,
    output logic [1:0]       state,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rd_ptr;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    remaining;
    logic [FW-1:0]    pcnt;
    logic             loaded;
    logic             wr_en;
    logic             clr;
    logic             load;
    logic             xfer;

    assign state    = cur;
    // The first DONE cycle only loads the read pointer, so rd_valid lags DONE by one cycle.
    assign rd_valid = (cur == S_DONE) && loaded && (remaining != '0);
    assign rd_last  = rd_valid && (remaining == FW'(1));
    assign rd_data  = mem[rd_ptr];
    assign xfer     = rd_valid && rd_ready;

    always_comb begin
        nxt   = cur;
        wr_en = 1'b0;
        clr   = 1'b0;
        load  = 1'b0;
        case (cur)
            S_IDLE: begin
                if (arm) begin
                    nxt = S_ARMED;
                    clr = 1'b1;
                end
            end
            S_ARMED: begin
                wr_en = smp_en;
                if (trig) nxt = (POST == 0) ? S_DONE : S_POST;
            end
            S_POST: begin
                wr_en = smp_en;
                if (smp_en && pcnt == FW'(1)) nxt = S_DONE;
            end
            S_DONE: begin
                // arm takes priority over a simultaneous final transfer
                if (arm) begin
                    nxt = S_ARMED;
                    clr = 1'b1;
                end else if (!loaded) begin
                    load = 1'b1;
                    if (fill == '0) nxt = S_IDLE;
                end else if (xfer && rd_last) begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            ov        <= '0;
            chg       <= 1'b0;
            wptr      <= '0;
            fill      <= '0;
            pcnt      <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            loaded    <= 1'b0;
        end else begin
            ov  <= v;
            chg <= (v != ov);
            if (clr) begin
                wptr <= '0;
                fill <= '0;
            end else if (wr_en) begin
                wptr <= wptr + 1'b1;
                if (fill != FW'(DEPTH)) fill <= fill + 1'b1;
            end
            if (cur == S_ARMED && trig)      pcnt <= FW'(POST);
            else if (cur == S_POST && smp_en) pcnt <= pcnt - 1'b1;
            loaded <= (cur == S_DONE) && (nxt == S_DONE);
            // A full buffer gives fill[AW-1:0] == 0, so the oldest entry is at wptr.
            if (load) begin
                rd_ptr    <= wptr - fill[AW-1:0];
                remaining <= fill;
            end else if (xfer) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    always_ff @(posedge fclk) begin
        if (wr_en) mem[wptr] <= v;
    end
endmodule

// File: tb/tb_ixc_sample_hist.sv
// tb/tb_ixc_sample_hist.sv - randomized and directed checks of ixc_sample_hist against a queue model
module tb_ixc_sample_hist;
    localparam int W = 8;
    localparam int D = 8;
    localparam int P = 4;

    logic         fclk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] v = '0;
    logic         smp_en = 1'b0;
    logic         arm = 1'b0;
    logic         trig = 1'b0;
    logic         rd_ready = 1'b0;
    logic [W-1:0] ov, rd_data, ov0, rd_data0;
    logic         chg, rd_valid, rd_last, chg0, rd_valid0, rd_last0;
    logic [1:0]   state, state0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 fclk = ~fclk;

    ixc_sample_hist #(.WIDTH(W), .DEPTH(D), .POST(P)) dut (
        .fclk(fclk), .rst(rst), .v(v), .ov(ov), .chg(chg), .smp_en(smp_en),
        .arm(arm), .trig(trig), .state(state), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
    );

    ixc_sample_hist #(.WIDTH(W), .DEPTH(D), .POST(0)) dut0 (
        .fclk(fclk), .rst(rst), .v(v), .ov(ov0), .chg(chg0), .smp_en(smp_en),
        .arm(arm), .trig(trig), .state(state0), .rd_valid(rd_valid0),
        .rd_ready(rd_ready), .rd_data(rd_data0), .rd_last(rd_last0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model of the POST=P instance: a queue of written samples, readout is its tail.
    int           m_state;
    logic [W-1:0] m_ov;
    logic         m_chg;
    logic [W-1:0] hist[$];
    logic [W-1:0] rdq[$];
    int           m_post;
    bit           m_loaded;
    bit           m_xv;

    function automatic bit m_valid();
        return (m_state == 3) && m_loaded && (rdq.size() != 0);
    endfunction

    always @(posedge fclk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_ov = '0; m_chg = 1'b0; m_post = 0; m_loaded = 1'b0;
            hist.delete(); rdq.delete();
        end else begin
            m_xv  = m_valid() && rd_ready;
            m_chg = (v != m_ov);
            m_ov  = v;
            case (m_state)
                0: if (arm) begin hist.delete(); m_state = 1; end
                1: begin
                    if (smp_en) hist.push_back(v);
                    if (trig) begin
                        m_loaded = 1'b0;
                        if (P == 0) m_state = 3;
                        else begin m_post = P; m_state = 2; end
                    end
                end
                2: if (smp_en) begin
                    hist.push_back(v);
                    m_post--;
                    if (m_post == 0) begin m_state = 3; m_loaded = 1'b0; end
                end
                default: begin
                    if (arm) begin
                        hist.delete(); rdq.delete(); m_loaded = 1'b0; m_state = 1;
                    end else if (!m_loaded) begin
                        m_loaded = 1'b1;
                        rdq = hist;
                        if (rdq.size() == 0) m_state = 0;
                    end else if (m_xv) begin
                        void'(rdq.pop_front());
                        if (rdq.size() == 0) m_state = 0;
                    end
                end
            endcase
            while (hist.size() > D) void'(hist.pop_front());
        end
    end

    always @(negedge fclk) begin
        if (cmp_en && !rst) begin
            chk("ov", ov, m_ov);
            chk("chg", chg, m_chg);
            chk("state", state, m_state);
            chk("rd_valid", rd_valid, m_valid());
            if (m_valid()) begin
                chk("rd_data", rd_data, rdq[0]);
                chk("rd_last", rd_last, rdq.size() == 1);
            end
        end
    end

    task automatic cyc();
        @(posedge fclk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    logic [W-1:0] got[$];
    int           last_at;

    task automatic drain(input bit use0, input bit stall);
        logic         vld, lst, prev_stall;
        logic [W-1:0] dat, prev_dat;
        got.delete(); last_at = -1; prev_stall = 1'b0; prev_dat = '0;
        for (int n = 0; n < 64; n++) begin
            vld = use0 ? rd_valid0 : rd_valid;
            lst = use0 ? rd_last0 : rd_last;
            dat = use0 ? rd_data0 : rd_data;
            if (prev_stall) chk("stall_hold", dat, prev_dat);
            rd_ready = stall ? (n % 4 == 0 || n % 4 == 3) : 1'b1;
            if (vld && rd_ready) begin
                got.push_back(dat);
                if (lst) last_at = got.size() - 1;
            end
            prev_stall = vld && !rd_ready;
            prev_dat = dat;
            cyc();
            if ((use0 ? state0 : state) == 2'd0) break;
        end
        rd_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge fclk);
        #1;
        chk("rst_ov", ov, 0);
        chk("rst_chg", chg, 0);
        chk("rst_state", state, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_last", rd_last, 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Trigger at v=10 with POST=4: DONE once 14 is written, readout 7..14.
        arm = 1'b1; cyc(); arm = 1'b0;
        chk("a_armed", state, 1);
        for (int i = 1; i <= 14; i++) begin
            v = W'(i); smp_en = 1'b1; trig = (i == 10);
            cyc();
            if (i == 13) chk("a_post", state, 2);
        end
        smp_en = 1'b0; trig = 1'b0;
        chk("a_done", state, 3);
        chk("a_first_valid", rd_valid, 0);
        drain(1'b0, 1'b0);
        chk("a_len", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) chk("a_word", got[i], 7 + i);
        chk("a_last_at", last_at, 7);
        chk("a_idle", state, 0);

        // Stalled readout with rd_ready pattern 1,0,0,1.
        arm = 1'b1; cyc(); arm = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            v = W'(i); smp_en = 1'b1; trig = (i == 8);
            cyc();
        end
        smp_en = 1'b0; trig = 1'b0;
        drain(1'b0, 1'b1);
        chk("b_len", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) chk("b_word", got[i], 5 + i);
        chk("b_last_at", last_at, 7);

        // arm together with the final transfer wins.
        arm = 1'b1; cyc(); arm = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            v = W'(i); smp_en = 1'b1; trig = (i == 2);
            cyc();
        end
        smp_en = 1'b0; trig = 1'b0; rd_ready = 1'b1;
        for (int n = 0; n < 40 && !(rd_valid && rd_last); n++) cyc();
        chk("b2_last_seen", rd_valid && rd_last, 1);
        chk("b2_last_data", rd_data, 6);
        arm = 1'b1; cyc(); arm = 1'b0; rd_ready = 1'b0;
        chk("b2_arm_wins", state, 1);
        cyc();
        chk("b2_stays_armed", state, 1);

        // v = 0,5,5,0 with smp_en low; POST=0 instance sees an empty DONE.
        rst_pulse();
        arm = 1'b1; v = 8'd0; cyc(); arm = 1'b0;
        v = 8'd0; cyc();
        v = 8'd5; cyc();
        chk("c_ov5", ov, 5); chk("c_chg_rise", chg, 1);
        v = 8'd5; cyc();
        chk("c_ov5b", ov, 5); chk("c_chg_hold", chg, 0);
        v = 8'd0; trig = 1'b1; cyc(); trig = 1'b0;
        chk("c_ov0", ov, 0); chk("c_chg_fall", chg, 1);
        chk("c0_done", state0, 3); chk("c0_no_valid", rd_valid0, 0);
        cyc();
        chk("c_chg_quiet", chg, 0);
        chk("c0_idle", state0, 0); chk("c0_no_valid2", rd_valid0, 0);

        // POST=0: trigger after three writes goes straight to DONE.
        rst_pulse();
        arm = 1'b1; cyc(); arm = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            v = W'(i); smp_en = 1'b1; trig = (i == 3);
            cyc();
        end
        smp_en = 1'b0; trig = 1'b0;
        chk("d0_done", state0, 3);
        drain(1'b1, 1'b0);
        chk("d0_len", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("d0_word", got[i], 1 + i);
        chk("d0_last_at", last_at, 2);
        chk("d0_idle", state0, 0);

        // Reset asserted mid-readout clears outputs at once.
        rst_pulse();
        arm = 1'b1; cyc(); arm = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            v = W'($urandom); smp_en = 1'b1; trig = (i == 3);
            cyc();
        end
        smp_en = 1'b0;
        for (int n = 0; n < 10 && !rd_valid; n++) cyc();
        chk("e_valid", rd_valid, 1);
        v = 8'h5A; cyc();
        v = 8'hA5; cyc();
        chk("e_pre_ov", ov, 8'hA5);
        #2 rst = 1'b1;
        #1;
        chk("e_ov", ov, 0); chk("e_chg", chg, 0);
        chk("e_state", state, 0); chk("e_valid0", rd_valid, 0);
        @(posedge fclk); #1; rst = 1'b0;
        repeat (3) cyc();
        chk("e_stays_idle", state, 0);

        for (int n = 0; n < 3000; n++) begin
            v        = W'($urandom);
            smp_en   = ($urandom_range(3) != 0);
            arm      = ($urandom_range(19) == 0);
            trig     = ($urandom_range(9) == 0);
            rd_ready = $urandom_range(1);
            rst      = ($urandom_range(499) == 0);
            cyc();
        end
        rst = 1'b0; arm = 1'b0; trig = 1'b0; smp_en = 1'b0; rd_ready = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ixc_sample_hist.md
# ixc_sample_hist

Parametrised successor to the single-bit sample flop: registers a WIDTH-bit probe vector every fast clock and also keeps a DEPTH-entry circular history around a trigger event. The history is streamed out oldest-first over a valid/ready port. It sits in the IXCOM temp library beside the plain samplers and feeds the debug capture path. It must stay always-on across power domains.

## Interface
- WIDTH, default 1: probe vector width (≥1).
- DEPTH, default 8: history entries; power of two, ≥2.
- POST, default 4: samples stored after the trigger cycle; range 0..DEPTH-1.

- fclk  in  1  fast clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- v  in  WIDTH  probe input.
- ov  out  WIDTH  registered v (legacy sampler output).
- chg  out  1  registered flag: v differed from ov in the previous cycle.
- smp_en  in  1  qualifies history writes.
- arm  in  1  start (or restart) a capture.
- trig  in  1  trigger event.
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- rd_valid  out  1  history word available.
- rd_ready  in  1  consumer accepts word.
- rd_data  out  WIDTH  history word, oldest first.
- rd_last  out  1  marks final word, valid only with rd_valid.

## Operation
- ov: loads v every cycle, independent of state and smp_en.
- chg: loads (v != ov) every cycle. The first nonzero v after reset therefore raises chg.
- History memory: DEPTH×WIDTH, write pointer wptr, fill counter of clog2(DEPTH+1) bits that saturates at DEPTH.
- A "write" means: mem[wptr] <= v; wptr <= wptr+1 mod DEPTH; fill <= min(fill+1, DEPTH).
- IDLE: no writes; rd_valid=0. arm → ARMED, clearing fill and wptr.
- ARMED: write on every smp_en cycle; arm is ignored.
  - trig → POST with post counter = POST. The trigger-cycle sample is written if smp_en.
  - trig with POST=0 → DONE directly.
- POST: write on every smp_en cycle, decrementing the counter. When a write takes the counter to 0 → DONE. trig and arm are ignored.
- DONE: no writes.
  - Read pointer starts at (wptr − fill) mod DEPTH, with remaining = fill.
  - rd_valid = (remaining ≠ 0); rd_data = mem[rd_ptr] (combinational); rd_last = (remaining == 1).
  - Transfer when rd_valid & rd_ready: rd_ptr++ mod DEPTH, remaining−−.
  - After the transfer with rd_last → IDLE.
  - fill = 0 at entry: rd_valid stays 0, → IDLE next cycle.
  - arm in DONE aborts the readout → ARMED with fill and wptr cleared. arm wins over a simultaneous final transfer.
- Memory contents are not reset. They are unreachable after reset because fill = 0.

## Timing
- Reset values: ov=0, chg=0, state=IDLE, rd_valid=0, rd_last=0, rd_data don't-care, fill=0, wptr=0, post counter=0.
- Reset asserted mid-capture or mid-readout: everything returns to the reset values immediately (asynchronous). Any partial stream is abandoned.
- ov latency is 1 cycle from v; chg reflects v(t−1) ≠ v(t−2).
- State changes take effect the cycle after the qualifying input.
- First rd_valid appears 1 cycle after state becomes DONE.
- rd_data and rd_last stay stable while rd_valid & !rd_ready. Sustained rd_ready gives 1 word per cycle.
- Wrap-around: more than DEPTH writes overwrite the oldest entries; the readout returns exactly the last DEPTH writes in order.
- smp_en low cycles write nothing and do not advance the post counter.

## Test plan
- Reset mid-readout: assert rst while rd_valid=1 → ov=0, chg=0, state=0, rd_valid=0 in the same cycle. After release, state stays IDLE.
- WIDTH=8, DEPTH=8, POST=4: arm, drive v=1,2,3,… with smp_en=1, trig at v=10.
  - Expect DONE after v=14 is written.
  - Readout gives 7..14; rd_last on 14; then IDLE.
- Same configuration, trig after only 3 writes (v=1..3, trig on v=3), POST=0 → DONE at once, readout 1,2,3, rd_last on 3.
- Same configuration, rd_ready toggling 1,0,0,1 during readout → rd_data holds steady while stalled, no word lost or duplicated. Also check arm together with the final transfer → state ARMED and no return to IDLE.
- Same configuration, v sequence 0,5,5,0 with smp_en=0 throughout the capture:
  - ov lags v by 1 cycle; chg pulses at the correct cycles.
  - fill stays 0, so DONE produces no rd_valid and returns to IDLE next cycle.
